// File: rtl/wrt_ptr_ctrl_ext.sv
// Write-domain pointer/flag controller for the async FIFO.
// Synchronises the read Gray pointer and derives full, level, almost-full, overflow.
module wrt_ptr_ctrl_ext #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wrt_clk,
    input  logic                 wrt_rst,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    input  logic                 wrt_inc,
    input  logic [ADDR_SIZE:0]   af_thresh,
    input  logic                 ovf_clr,
    output logic                 wrt_en,
    output logic [ADDR_SIZE-1:0] wrt_addr,
    output logic [ADDR_SIZE:0]   wrt_ptr,
    output logic                 wrt_full,
    output logic                 wrt_almost_full,
    output logic [ADDR_SIZE:0]   wrt_level,
    output logic                 wrt_ovf
);

    logic [ADDR_SIZE:0] sync_q [SYNC_STAGES];
    logic [ADDR_SIZE:0] sync_rd_gray;
    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] wrt_bin_q;
    logic [ADDR_SIZE:0] wrt_bin_d;
    logic [ADDR_SIZE:0] gray_d;
    logic [ADDR_SIZE:0] level_d;
    logic [ADDR_SIZE:0] full_cmp;
    logic [ADDR_SIZE:0] wrt_ptr_q;
    logic [ADDR_SIZE:0] level_q;
    logic               full_q;
    logic               af_q;
    logic               ovf_q;

    // Read pointer crosses into the write domain through a plain flop chain
    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_rd_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) rd_bin[i] = ^(sync_rd_gray >> i);
    end

    assign wrt_en    = wrt_inc & ~full_q;
    assign wrt_bin_d = wrt_bin_q + {{ADDR_SIZE{1'b0}}, wrt_en};
    assign gray_d    = (wrt_bin_d >> 1) ^ wrt_bin_d;
    assign level_d   = wrt_bin_d - rd_bin;
    // Full when the write pointer is exactly one lap ahead of the read pointer
    assign full_cmp  = {~sync_rd_gray[ADDR_SIZE:ADDR_SIZE-1],
                        sync_rd_gray[ADDR_SIZE-2:0]};

    // Pointer, level and flag registers
    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            wrt_bin_q <= '0;
            wrt_ptr_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
        end else begin
            wrt_bin_q <= wrt_bin_d;
            wrt_ptr_q <= gray_d;
            level_q   <= level_d;
            full_q    <= (gray_d == full_cmp);
            af_q      <= (level_d >= af_thresh);
        end
    end

    // Sticky overflow: a dropped request wins over a simultaneous clear
    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst)                 ovf_q <= 1'b0;
        else if (wrt_inc && full_q)  ovf_q <= 1'b1;
        else if (ovf_clr)            ovf_q <= 1'b0;
    end

    assign wrt_addr        = wrt_bin_q[ADDR_SIZE-1:0];
    assign wrt_ptr         = wrt_ptr_q;
    assign wrt_full        = full_q;
    assign wrt_almost_full = af_q;
    assign wrt_level       = level_q;
    assign wrt_ovf         = ovf_q;

endmodule

// File: doc/wrt_ptr_ctrl_ext.md
Name: wrt_ptr_ctrl_ext

Overview:
Write-domain pointer and flag controller for the asynchronous FIFO. It is the generalised successor of the basic write-pointer generator. It adds the following:
- an internal parametrised read-pointer synchroniser
- a fill-level output
- a programmable almost-full flag
- a sticky overflow flag

It sits between the write-side client, the dual-port RAM write port and the read-domain Gray pointer.

Parameters:
ADDR_SIZE, 4, RAM address width; DEPTH = 2**ADDR_SIZE entries
SYNC_STAGES, 2, flop stages on the incoming read Gray pointer (legal 2..4)

Ports:
wrt_clk  in  1  write-domain clock
wrt_rst  in  1  reset, asynchronous, active-high
rd_ptr_gray  in  ADDR_SIZE+1  read Gray pointer, asynchronous to wrt_clk
wrt_inc  in  1  write request
af_thresh  in  ADDR_SIZE+1  almost-full threshold in entries, quasi-static
ovf_clr  in  1  clears wrt_ovf
wrt_en  out  1  RAM write enable (combinational)
wrt_addr  out  ADDR_SIZE  RAM write address
wrt_ptr  out  ADDR_SIZE+1  registered write Gray pointer to read domain
wrt_full  out  1  FIFO full
wrt_almost_full  out  1  level >= af_thresh
wrt_level  out  ADDR_SIZE+1  occupancy as seen from write domain, 0..DEPTH
wrt_ovf  out  1  sticky: write attempted while full

Behaviour:
- Reset (async, no clock needed):
  - wrt_bin, wrt_ptr, all sync flops, wrt_full, wrt_almost_full, wrt_level and wrt_ovf go to 0.
  - wrt_en = 0 while wrt_inc = 0.
- Synchroniser:
  - SYNC_STAGES-deep flop chain on rd_ptr_gray, clocked by wrt_clk.
  - sync_rd_gray is the last stage.
  - No other logic reads rd_ptr_gray.
- rd_bin is the Gray-to-binary conversion of sync_rd_gray (combinational XOR prefix from the MSB).
- wrt_en = wrt_inc & ~wrt_full. A request while full is dropped, not queued.
- wrt_addr = wrt_bin[ADDR_SIZE-1:0].
- Next-state values:
  - wrt_bin_nxt = wrt_bin + wrt_en, modulo 2**(ADDR_SIZE+1).
  - gray_nxt = (wrt_bin_nxt >> 1) ^ wrt_bin_nxt.
- Registered each wrt_clk edge:
  - wrt_bin <= wrt_bin_nxt
  - wrt_ptr <= gray_nxt
  - wrt_full <= (gray_nxt == {~sync_rd_gray[ADDR_SIZE:ADDR_SIZE-1], sync_rd_gray[ADDR_SIZE-2:0]})
  - wrt_level <= wrt_bin_nxt - rd_bin, modulo 2**(ADDR_SIZE+1); never exceeds DEPTH
  - wrt_almost_full <= (level_nxt >= af_thresh)
- Flags are pessimistic:
  - Full and level reflect read progress SYNC_STAGES+1 edges late.
  - Full deassertion therefore lags a read by SYNC_STAGES+1 edges.
  - Full assertion occurs on the same edge that commits the filling write.
- Overflow flag:
  - wrt_ovf sets on an edge where wrt_inc & wrt_full.
  - It clears on an edge where ovf_clr = 1.
  - Set has priority over clear when both occur on the same edge.
- Threshold edge cases:
  - af_thresh = 0: wrt_almost_full = 1 from the first edge after reset.
  - af_thresh > DEPTH: wrt_almost_full never asserts.
- Wrap-around: binary wraps 2**(ADDR_SIZE+1)-1 -> 0 and Gray wraps accordingly. The flag logic needs no special casing.
- Gray invariant: wrt_ptr changes at most one bit per edge.
- Reset mid-operation: all state clears immediately; the first write after release goes to address 0.

Test Plan:
(ADDR_SIZE=4, SYNC_STAGES=2, af_thresh=14, rd_ptr_gray=0 unless stated)
1. Reset release:
   - Expect wrt_ptr=0, wrt_addr=0, wrt_full=0, wrt_level=0, wrt_almost_full=0, wrt_ovf=0.
2. Fill, wrt_inc=1 for 16 cycles:
   - wrt_en high for 16 cycles; wrt_addr 0..15.
   - wrt_almost_full=1 on the edge of the 14th write.
   - On the 16th edge: wrt_full=1, wrt_ptr=5'b11000, wrt_level=16.
3. Overflow, then 3 more wrt_inc cycles while full:
   - wrt_en=0 and wrt_ptr unchanged; wrt_ovf=1 after the first of these edges.
   - ovf_clr pulse with wrt_inc=0 -> wrt_ovf=0.
   - ovf_clr and overflow on the same edge -> wrt_ovf stays 1.
4. Drain latency, while full: drive rd_ptr_gray = 5'b00110 (binary 4):
   - wrt_full falls exactly 3 edges later, with wrt_level=12 and wrt_almost_full=0.
5. Wrap: 40 writes while the read-side model keeps 8 entries behind:
   - wrt_ptr goes 5'b10000 -> 5'b00000 at the binary 31 -> 0 transition.
   - wrt_full never asserts; one Gray bit changes per write.
6. Reset mid-operation: wrt_rst asserted between clock edges with wrt_level=9:
   - All outputs go to 0 before the next wrt_clk edge.
   - After release, the first write uses wrt_addr=0.
